pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_channel.sv | 38 +++
 rtl/pwm_multi.sv | 141 ++++++++++++++
 tb/tb_pwm_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM block.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty staging register, active (shadow) duty, compare and
// registered, polarity-adjusted output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int   WIDTH = 4,
  parameter logic POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_cnt,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_stg;
  logic [WIDTH-1:0] r_duty;
  logic             r_out;

  // Stage writes, promote to active duty on load, register the compare result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg  <= '0;
      r_duty <= '0;
      r_out  <= POL;
    end else begin
      if (i_we)   r_stg  <= i_data;
      if (i_load) r_duty <= r_stg;
      r_out <= i_en ? ((i_cnt < r_duty) ^ POL) : POL;
    end
  end

  assign o_pwm = r_out;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler, edge/center-aligned period counter and
// boundary-synchronised shadow loading of period, mode and duties.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                  WIDTH    = 4,
  parameter int                  CHANNELS = 4,
  parameter int                  PRESC_W  = 8,
  parameter logic [CHANNELS-1:0] POLARITY = '0,
  localparam int                 SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic [WIDTH-1:0]    period,
  input  logic                mode,
  input  logic                duty_we,
  input  logic [SEL_W-1:0]    duty_sel,
  input  logic [WIDTH-1:0]    duty_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_end
);

  logic [PRESC_W-1:0] r_presc;
  logic [WIDTH-1:0]   r_cnt;
  cnt_dir_e           r_dir;
  logic [WIDTH-1:0]   r_stg_period;
  pwm_mode_e          r_stg_mode;
  logic [WIDTH-1:0]   r_period;
  pwm_mode_e          r_mode;
  logic               r_pend;

  logic               w_tick;
  logic               w_boundary;
  logic               w_load;
  logic [WIDTH-1:0]   w_cnt_nxt;
  cnt_dir_e           w_dir_nxt;
  logic [CHANNELS-1:0] w_we;

  assign w_tick = (r_presc == prescale);
  assign w_load = !en || w_boundary;

  // Prescaler: free-runs 0..prescale while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (!en || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Counter next-state: edge wraps at P; center climbs to P then descends to 1.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    w_boundary = 1'b0;
    if (en && w_tick) begin
      if (r_mode == PWM_EDGE) begin
        if (r_cnt == r_period) w_boundary = 1'b1;
        else                   w_cnt_nxt  = r_cnt + 1'b1;
      end else if (r_dir == CNT_UP) begin
        if (r_cnt == r_period) begin
          if (r_period <= WIDTH'(1)) begin
            w_boundary = 1'b1;
          end else begin
            w_dir_nxt = CNT_DOWN;
            w_cnt_nxt = r_period - 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end else begin
        if (r_cnt == WIDTH'(1)) w_boundary = 1'b1;
        else                    w_cnt_nxt  = r_cnt - 1'b1;
      end
      if (w_boundary) begin
        w_cnt_nxt = '0;
        w_dir_nxt = CNT_UP;
      end
    end
    if (!en) begin
      w_cnt_nxt = '0;
      w_dir_nxt = CNT_UP;
    end
  end

  // Counter/direction state register and period boundary pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dir  <= CNT_UP;
      r_pend <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_dir  <= w_dir_nxt;
      r_pend <= w_boundary;
    end
  end

  // Staging samples every cycle; active copies only at a boundary (or when idle),
  // so a write coinciding with a boundary waits for the following one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_period <= '1;
      r_stg_mode   <= PWM_EDGE;
      r_period     <= '1;
      r_mode       <= PWM_EDGE;
    end else begin
      r_stg_period <= period;
      r_stg_mode   <= pwm_mode_e'(mode);
      if (w_load) begin
        r_period <= r_stg_period;
        r_mode   <= r_stg_mode;
      end
    end
  end

  assign period_end = r_pend;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign w_we[gi] = duty_we && (duty_sel == SEL_W'(gi));

    pwm_channel #(
      .WIDTH (WIDTH),
      .POL   (POLARITY[gi])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_en   (en),
      .i_we   (w_we[gi]),
      .i_data (duty_data),
      .i_load (w_load),
      .i_cnt  (r_cnt),
      .o_pwm  (pwm_out[gi])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus queues per-period expectations,
// a monitor measures each period (delimited by period_end) and compares.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] prescale;
  logic [3:0] period;
  logic       mode;
  logic       duty_we;
  logic [1:0] duty_sel;
  logic [3:0] duty_data;
  logic [3:0] pwm_out;
  logic       period_end;
  logic [3:0] pwm_out_pol;
  logic       period_end_pol;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] h0;
    logic [15:0] h1;
    logic [15:0] h2;
    logic [15:0] h3;
    logic [31:0] pat0;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(4), .CHANNELS(4), .PRESC_W(8), .POLARITY(4'b0000)) u_dut (
    .clk(clk), .rst(rst), .en(en), .prescale(prescale), .period(period),
    .mode(mode), .duty_we(duty_we), .duty_sel(duty_sel), .duty_data(duty_data),
    .pwm_out(pwm_out), .period_end(period_end)
  );

  pwm_multi #(.WIDTH(4), .CHANNELS(4), .PRESC_W(8), .POLARITY(4'b0001)) u_dut_pol (
    .clk(clk), .rst(rst), .en(en), .prescale(prescale), .period(period),
    .mode(mode), .duty_we(duty_we), .duty_sel(duty_sel), .duty_data(duty_data),
    .pwm_out(pwm_out_pol), .period_end(period_end_pol)
  );

  task automatic check(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic push(input int len, input int h0, input int h1, input int h2,
                      input int h3, input int pat0);
    exp_t e;
    e.len = 16'(len); e.h0 = 16'(h0); e.h1 = 16'(h1); e.h2 = 16'(h2);
    e.h3 = 16'(h3); e.pat0 = 32'(pat0);
    sb_q.push_back(e);
  endtask

  task automatic write_duty(input int ch, input int d);
    duty_sel  = 2'(ch);
    duty_data = 4'(d);
    duty_we   = 1'b1;
    @(posedge clk); #1;
    duty_we   = 1'b0;
  endtask

  // Only called with en = 0; two extra cycles let staging reach the active copy.
  task automatic cfg(input int p, input int m, input int ps,
                     input int d0, input int d1, input int d2, input int d3);
    period   = 4'(p);
    mode     = m[0];
    prescale = 8'(ps);
    write_duty(0, d0);
    write_duty(1, d1);
    write_duty(2, d2);
    write_duty(3, d3);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_stop(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
    en = 1'b0;
    check("sb_drained", sb_q.size(), 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: accumulate one period of output between period_end pulses.
  initial begin
    int          acc_len;
    int          acc_h[4];
    int          acc_hp0;
    logic [31:0] acc_pat;
    logic        en_prev;
    exp_t        e;
    acc_len = 0; acc_hp0 = 0; acc_pat = '0; en_prev = 1'b0;
    foreach (acc_h[c]) acc_h[c] = 0;
    forever begin
      @(negedge clk);
      if (rst || !en_prev) begin
        acc_len = 0; acc_hp0 = 0; acc_pat = '0;
        foreach (acc_h[c]) acc_h[c] = 0;
      end else begin
        if (acc_len < 32) acc_pat[acc_len] = pwm_out[0];
        acc_len++;
        for (int c = 0; c < 4; c++) acc_h[c] += int'(pwm_out[c]);
        acc_hp0 += int'(pwm_out_pol[0]);
        if (period_end) begin
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("period_len", acc_len, int'(e.len));
            check("hi_ch0", acc_h[0], int'(e.h0));
            check("hi_ch1", acc_h[1], int'(e.h1));
            check("hi_ch2", acc_h[2], int'(e.h2));
            check("hi_ch3", acc_h[3], int'(e.h3));
            check("pattern_ch0", int'(acc_pat), int'(e.pat0));
            check("hi_pol_ch0", acc_hp0, int'(e.len) - int'(e.h0));
          end
          acc_len = 0; acc_hp0 = 0; acc_pat = '0;
          foreach (acc_h[c]) acc_h[c] = 0;
        end
      end
      en_prev = en && !rst;
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; duty_we = 1'b0; prescale = '0;
    period = 4'd15; duty_sel = '0; duty_data = '0;
    #1;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_pwm_out_pol", int'(pwm_out_pol), 1);
    check("rst_period_end", int'(period_end), 0);
    check("rst_active_period", int'(u_dut.r_period), 15);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Edge, P=15, prescale 0
    cfg(15, 0, 0, 5, 0, 15, 8);
    check("idle_pwm_out", int'(pwm_out), 0);
    check("idle_pwm_out_pol", int'(pwm_out_pol), 1);
    check("idle_period_end", int'(period_end), 0);
    repeat (3) push(16, 5, 0, 15, 8, 32'h1F);
    en = 1'b1;
    run_stop(52);

    // Edge, P=9: duty 0 / duty > P / duty = P
    cfg(9, 0, 0, 3, 0, 12, 9);
    repeat (2) push(10, 3, 0, 10, 9, 32'h7);
    en = 1'b1;
    run_stop(24);

    // Same with prescale 2: every count held three cycles
    cfg(9, 0, 2, 3, 0, 12, 9);
    repeat (2) push(30, 9, 0, 30, 27, 32'h1FF);
    en = 1'b1;
    run_stop(64);

    // Mid-period duty write waits for the boundary
    cfg(15, 0, 0, 2, 4, 0, 0);
    push(16, 2, 4, 0, 0, 32'h3);
    push(16, 2, 10, 0, 0, 32'h3);
    en = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    write_duty(1, 10);
    run_stop(28);

    // Center, P=7
    cfg(7, 1, 0, 3, 7, 8, 0);
    repeat (3) push(14, 5, 13, 14, 0, 32'h3007);
    en = 1'b1;
    run_stop(46);

    // Mode edge->center and P 15->3 mid-period
    cfg(15, 0, 0, 5, 2, 0, 15);
    push(16, 5, 2, 0, 15, 32'h1F);
    repeat (2) push(6, 6, 3, 0, 6, 32'h3F);
    en = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    mode   = 1'b1;
    period = 4'd3;
    run_stop(25);

    // Asynchronous reset mid-period
    cfg(15, 0, 0, 5, 0, 0, 0);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_out_ch0", int'(pwm_out[0]), 1);
    check("pre_rst_pol_ch0", int'(pwm_out_pol[0]), 0);
    rst = 1'b1;
    #1;
    check("async_rst_pwm_out", int'(pwm_out), 0);
    check("async_rst_pwm_out_pol", int'(pwm_out_pol), 1);
    check("async_rst_period_end", int'(period_end), 0);
    check("async_rst_counter", int'(u_dut.r_cnt), 0);
    @(posedge clk);
    #1;
    en  = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
